ad9643_spi_cfg: RTL and testbench

Configuration controller for the AD9643 3‑wire SPI port (sclk/csb/sdio). After reset it waits a power‑on interval, then writes a fixed initialisation sequence ending with the register‑transfer command. It then serves single‑byte read/write requests from a host port, one frame at a time. It sits between system control logic and the ADC model's SPI pins; the ADC DDR datapath is untouched.

---
 rtl/ad9643_spi_cfg.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ad9643_spi_cfg.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9643_spi_cfg.sv
// ad9643_spi_cfg
//   Configuration master for the AD9643 3-wire SPI port. After reset it waits
//   POR_WAIT cycles and then writes a fixed four-frame init sequence. The last
//   frame of that sequence is the register-transfer command. From then on it
//   serves one single-byte host read or write per request.
//
// Parameters
//   CLK_DIV   sclk half-period in clk cycles (>= 2)
//   POR_WAIT  clk cycles from reset release to the first init LOAD (>= 1)
//   CSB_GAP   idle cycles with csb high after each frame (>= 1)
//
// Ports
//   clk, rst                  system clock, async active-high reset
//   host_req/rd/addr/wdata    level request; fields held until host_ack
//   host_ack                  one-cycle pulse in the last gap cycle of a host frame
//   host_rdata                read byte, updated together with host_ack on reads
//   init_done                 init sequence complete (sticky until rst)
//   busy                      low only while idle
//   sclk, csb, sdio_o/oe/i    SPI pins; sdio_oe=0 releases sdio to the ADC
module ad9643_spi_cfg #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned POR_WAIT = 64,
    parameter int unsigned CSB_GAP  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_req,
    input  logic        host_rd,
    input  logic [12:0] host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic        init_done,
    output logic        busy,
    output logic        sclk,
    output logic        csb,
    output logic        sdio_o,
    output logic        sdio_oe,
    input  logic        sdio_i
);

    localparam int unsigned CntMax =
        (POR_WAIT > CLK_DIV) ? ((POR_WAIT > CSB_GAP) ? POR_WAIT : CSB_GAP)
                             : ((CLK_DIV > CSB_GAP) ? CLK_DIV : CSB_GAP);
    localparam int unsigned CntW = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] PorLast = CntW'(POR_WAIT - 1);
    localparam logic [CntW-1:0] GapLast = CntW'(CSB_GAP - 1);

    typedef enum logic [2:0] {
        StPor,
        StLoad,
        StSetup,
        StShiftLo,
        StShiftHi,
        StHold,
        StGap,
        StIdle
    } state_e;

    function automatic logic [23:0] wr_word(input logic [12:0] addr, input logic [7:0] data);
        return {1'b0, 2'b00, addr, data};
    endfunction

    function automatic logic [23:0] init_word(input logic [1:0] idx);
        case (idx)
            2'd0:    return wr_word(13'h008, 8'h00);  // normal power mode
            2'd1:    return wr_word(13'h014, 8'h00);  // offset binary output
            2'd2:    return wr_word(13'h016, 8'h00);  // clock phase default
            default: return wr_word(13'h0FF, 8'h01);  // transfer
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [4:0]        bit_q, bit_d;
    logic [1:0]        idx_q, idx_d;
    logic              host_frame_q, host_frame_d;
    logic              rd_q, rd_d;
    logic [23:0]       tx_q, tx_d;
    logic [7:0]        rx_q, rx_d;
    logic              sclk_q, sclk_d;
    logic              csb_q, csb_d;
    logic              sdio_o_q, sdio_o_d;
    logic              sdio_oe_q, sdio_oe_d;
    logic              host_ack_q, host_ack_d;
    logic [7:0]        host_rdata_q, host_rdata_d;
    logic              init_done_q, init_done_d;
    logic              busy_q, busy_d;
    logic              in_frame;
    logic              released;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        idx_d        = idx_q;
        host_frame_d = host_frame_q;
        rd_d         = rd_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        init_done_d  = init_done_q;

        case (state_q)
            StPor: begin
                if (cnt_q == PorLast) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLoad: begin
                if (!init_done_q) begin
                    tx_d         = init_word(idx_q);
                    rd_d         = 1'b0;
                    host_frame_d = 1'b0;
                end else begin
                    tx_d         = {host_rd, 2'b00, host_addr, host_rd ? 8'h00 : host_wdata};
                    rd_d         = host_rd;
                    host_frame_d = 1'b1;
                end
                state_d = StSetup;
                cnt_d   = '0;
            end
            StSetup: begin
                if (cnt_q == DivLast) begin
                    state_d = StShiftLo;
                    cnt_d   = '0;
                    bit_d   = 5'd23;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShiftLo: begin
                if (cnt_q == DivLast) begin
                    state_d = StShiftHi;
                    cnt_d   = '0;
                    // Sample on the edge that raises sclk, data-phase bits only.
                    if (rd_q && (bit_q < 5'd8)) begin
                        rx_d = {rx_q[6:0], sdio_i};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShiftHi: begin
                if (cnt_q == DivLast) begin
                    cnt_d = '0;
                    if (bit_q == 5'd0) begin
                        state_d = StHold;
                    end else begin
                        state_d = StShiftLo;
                        bit_d   = bit_q - 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == DivLast) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d = '0;
                    if (host_frame_q) begin
                        state_d = StIdle;
                    end else if (idx_q == 2'd3) begin
                        init_done_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = StLoad;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (host_req && init_done_q) begin
                    state_d = StLoad;
                end
            end
            default: begin
                state_d = StPor;
                cnt_d   = '0;
            end
        endcase

        // Pin levels are registered from the next state so every pin changes
        // exactly on a phase boundary.
        in_frame = (state_d inside {StSetup, StShiftLo, StShiftHi, StHold});
        csb_d    = !in_frame;
        sclk_d   = (state_d == StShiftHi);

        sdio_o_d = sdio_o_q;
        if (!in_frame) begin
            sdio_o_d = 1'b0;
        end else if ((state_d == StShiftLo) && (state_q != StShiftLo)) begin
            sdio_o_d = tx_q[bit_d];
        end

        // On reads the ADC owns sdio from the bit-7 low phase until csb rises.
        released  = rd_q && (state_d inside {StShiftLo, StShiftHi, StHold}) && (bit_d < 5'd8);
        sdio_oe_d = in_frame && !released;

        host_ack_d   = host_frame_q && (state_d == StGap) && (cnt_d == GapLast);
        host_rdata_d = (host_ack_d && rd_q) ? rx_q : host_rdata_q;
        busy_d       = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StPor;
            cnt_q        <= '0;
            bit_q        <= '0;
            idx_q        <= '0;
            host_frame_q <= 1'b0;
            rd_q         <= 1'b0;
            tx_q         <= '0;
            rx_q         <= '0;
            sclk_q       <= 1'b0;
            csb_q        <= 1'b1;
            sdio_o_q     <= 1'b0;
            sdio_oe_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= 8'h00;
            init_done_q  <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            idx_q        <= idx_d;
            host_frame_q <= host_frame_d;
            rd_q         <= rd_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            sclk_q       <= sclk_d;
            csb_q        <= csb_d;
            sdio_o_q     <= sdio_o_d;
            sdio_oe_q    <= sdio_oe_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
            init_done_q  <= init_done_d;
            busy_q       <= busy_d;
        end
    end

    assign sclk       = sclk_q;
    assign csb        = csb_q;
    assign sdio_o     = sdio_o_q;
    assign sdio_oe    = sdio_oe_q;
    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;
    assign init_done  = init_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ad9643_spi_cfg.sv
// Bench for ad9643_spi_cfg. Instance A uses the default parameters, and
// instance B uses CLK_DIV=2, CSB_GAP=1 for back-to-back host writes. Monitors
// decode each SPI frame from the pins. They compare each frame and each
// host_ack against queues that the stimulus fills when it issues work.
module tb_ad9643_spi_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- instance A: defaults ----------------
    logic        rst = 1'b1;
    logic        host_req = 1'b0, host_rd = 1'b0;
    logic [12:0] host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic        host_ack, init_done, busy, sclk, csb, sdio_o, sdio_oe, sdio_i;
    logic [7:0]  host_rdata;
    logic [7:0]  stub_byte = 8'hA5;

    ad9643_spi_cfg #(.CLK_DIV(4), .POR_WAIT(64), .CSB_GAP(8)) u_dut_a (
        .clk(clk), .rst(rst), .host_req(host_req), .host_rd(host_rd),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
        .host_rdata(host_rdata), .init_done(init_done), .busy(busy), .sclk(sclk),
        .csb(csb), .sdio_o(sdio_o), .sdio_oe(sdio_oe), .sdio_i(sdio_i)
    );

    typedef struct {
        logic       rd;
        logic [7:0] rdata;
    } ack_t;

    logic [23:0] expq[$];
    ack_t        ackq[$];
    logic [7:0]  model_rdata = 8'h00;

    logic [4:0]  rises = '0;
    logic [23:0] shreg = '0, oe_hist = '0;
    int          low_cnt = 0;
    int          frames_started = 0;
    logic        p_csb = 1'b1, p_sclk = 1'b0, p_oe = 1'b0, p_ack = 1'b0;

    // ADC stub drives the data byte MSB first once sdio is released.
    assign sdio_i = (!csb && !sdio_oe && rises >= 5'd16 && rises <= 5'd23) ?
                    stub_byte[3'(5'd23 - rises)] : 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            p_csb  <= 1'b1;
            p_sclk <= 1'b0;
            p_oe   <= 1'b0;
            p_ack  <= 1'b0;
            rises  <= '0;
        end else begin
            p_csb  <= csb;
            p_sclk <= sclk;
            p_oe   <= sdio_oe;
            p_ack  <= host_ack;
            if (p_csb && !csb) begin
                rises          <= '0;
                low_cnt        <= 1;
                oe_hist        <= '0;
                shreg          <= '0;
                frames_started <= frames_started + 1;
            end else if (!csb) begin
                low_cnt <= low_cnt + 1;
                if (sclk && !p_sclk) begin
                    shreg   <= {shreg[22:0], sdio_o};
                    oe_hist <= {oe_hist[22:0], sdio_oe};
                    rises   <= rises + 5'd1;
                end
                if (p_oe && !sdio_oe)
                    chk("a_oe_fall_at_bit7_low", 32'({sclk, p_sclk, rises}),
                        32'({1'b0, 1'b1, 5'd16}));
            end
            if (!p_csb && csb) begin
                if (expq.size() == 0) begin
                    chk("a_unexpected_frame", 32'(expq.size()), 32'd1);
                end else begin
                    chk("a_frame_word", 32'(shreg), 32'(expq[0]));
                    chk("a_csb_low_cycles", 32'(low_cnt), 32'd200);
                    chk("a_sclk_rises", 32'(rises), 32'd24);
                    chk("a_oe_pattern", 32'(oe_hist),
                        expq[0][23] ? 32'h00FFFF00 : 32'h00FFFFFF);
                    chk("a_oe_off_after_csb", 32'(sdio_oe), 32'd0);
                    void'(expq.pop_front());
                end
            end
            if (host_ack) begin
                chk("a_ack_single_cycle", 32'(p_ack), 32'd0);
                if (ackq.size() == 0) begin
                    chk("a_unexpected_ack", 32'(ackq.size()), 32'd1);
                end else begin
                    chk(ackq[0].rd ? "a_read_rdata" : "a_write_rdata_unchanged",
                        32'(host_rdata), 32'(ackq[0].rdata));
                    void'(ackq.pop_front());
                end
            end
        end
    end

    // ---------------- instance B: CLK_DIV=2, CSB_GAP=1 ----------------
    logic        rst_b = 1'b1;
    logic        host_req_b = 1'b0;
    logic        host_ack_b, init_done_b, busy_b, sclk_b, csb_b, sdio_o_b, sdio_oe_b;
    logic [7:0]  host_rdata_b;

    ad9643_spi_cfg #(.CLK_DIV(2), .POR_WAIT(4), .CSB_GAP(1)) u_dut_b (
        .clk(clk), .rst(rst_b), .host_req(host_req_b), .host_rd(1'b0),
        .host_addr(13'h018), .host_wdata(8'h55), .host_ack(host_ack_b),
        .host_rdata(host_rdata_b), .init_done(init_done_b), .busy(busy_b),
        .sclk(sclk_b), .csb(csb_b), .sdio_o(sdio_o_b), .sdio_oe(sdio_oe_b),
        .sdio_i(1'b0)
    );

    logic [23:0] expb[$];
    logic [23:0] sh_b = '0;
    int          low_b = 0, gap_b = 0, starts_b = 0, ends_b = 0, acks_b = 0;
    logic        pb_csb = 1'b1, pb_sclk = 1'b0, pb_ack = 1'b0;
    logic        b_end_now;

    assign b_end_now = !pb_csb && csb_b;

    always @(negedge clk) begin
        if (rst_b) begin
            pb_csb  <= 1'b1;
            pb_sclk <= 1'b0;
            pb_ack  <= 1'b0;
        end else begin
            pb_csb  <= csb_b;
            pb_sclk <= sclk_b;
            pb_ack  <= host_ack_b;
            if (csb_b) gap_b <= pb_csb ? gap_b + 1 : 1;
            if (pb_csb && !csb_b) begin
                // Init frames: GAP+LOAD; after an IDLE visit: GAP+IDLE+LOAD.
                if (starts_b > 0)
                    chk("b_csb_high_gap", 32'(gap_b), (starts_b < 4) ? 32'd2 : 32'd3);
                starts_b <= starts_b + 1;
                low_b    <= 1;
                sh_b     <= '0;
            end else if (!csb_b) begin
                low_b <= low_b + 1;
                if (sclk_b && !pb_sclk) sh_b <= {sh_b[22:0], sdio_o_b};
            end
            if (b_end_now) begin
                ends_b <= ends_b + 1;
                chk("b_csb_low_cycles", 32'(low_b), 32'd100);
                if (expb.size() == 0) begin
                    chk("b_unexpected_frame", 32'(expb.size()), 32'd1);
                end else begin
                    chk("b_frame_word", 32'(sh_b), 32'(expb[0]));
                    void'(expb.pop_front());
                end
            end
            if (host_ack_b) begin
                acks_b <= acks_b + 1;
                chk("b_ack_single_cycle", 32'(pb_ack), 32'd0);
                chk("b_one_ack_per_frame", 32'(ends_b + int'(b_end_now)), 32'(acks_b + 5));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_init();
        expq.push_back(24'h000800);
        expq.push_back(24'h001400);
        expq.push_back(24'h001600);
        expq.push_back(24'h00FF01);
    endtask

    // Releases rst and times the first csb fall and the init_done rise. With
    // with_host set, a write request is raised during init frame 2.
    task automatic run_init(input bit with_host);
        int base, n_fall, n_done, n_host;
        base   = frames_started;
        n_fall = 0;
        n_done = 0;
        n_host = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 3000; n++) begin
            @(posedge clk);
            #1;
            if (!csb && n_fall == 0) n_fall = n;
            if (with_host && !host_req && frames_started == base + 2) begin
                host_rd    = 1'b0;
                host_addr  = 13'h018;
                host_wdata = 8'h04;
                host_req   = 1'b1;
                expq.push_back(24'h001804);
                ackq.push_back('{rd: 1'b0, rdata: model_rdata});
            end
            if (n_done != 0 && n == n_done + 1) chk("a_busy_in_load", 32'(busy), 32'd1);
            if (n_done != 0 && !csb) begin
                n_host = n;
                break;
            end
            if (init_done && n_done == 0) begin
                n_done = n;
                chk("a_busy_low_in_idle", 32'(busy), 32'd0);
                if (!with_host) break;
            end
        end
        chk("a_first_csb_fall", 32'(n_fall), 32'd65);
        chk("a_init_done_rise", 32'(n_done), 32'd900);
        if (with_host) chk("a_host_csb_latency", 32'(n_host - n_done), 32'd2);
    endtask

    task automatic wait_ack_a();
        bit got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (host_ack) begin
                got = 1'b1;
                break;
            end
        end
        chk("a_ack_seen", 32'(got), 32'd1);
        host_req = 1'b0;
    endtask

    initial begin
        bit found;
        int base;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_csb", 32'(csb), 32'd1);
        chk("rst_sdio_o", 32'(sdio_o), 32'd0);
        chk("rst_sdio_oe", 32'(sdio_oe), 32'd0);
        chk("rst_host_ack", 32'(host_ack), 32'd0);
        chk("rst_host_rdata", 32'(host_rdata), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        // Init sequence with a host write pending from frame 2 onwards.
        push_init();
        run_init(1'b1);
        wait_ack_a();

        // Host read of 0x001; the stub returns 0xA5.
        @(negedge clk);
        host_rd   = 1'b1;
        host_addr = 13'h001;
        expq.push_back(24'h800100);
        ackq.push_back('{rd: 1'b1, rdata: 8'hA5});
        model_rdata = 8'hA5;
        host_req  = 1'b1;
        wait_ack_a();

        // Reset during bit 10 of init frame 3, then a full rerun.
        @(negedge clk);
        rst = 1'b1;
        expq.delete();
        push_init();
        base = frames_started;
        @(negedge clk);
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (frames_started == base + 3 && rises == 5'd14) begin
                found = 1'b1;
                break;
            end
        end
        chk("a_reached_frame3_bit10", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_csb_high", 32'(csb), 32'd1);
        chk("midrst_sclk_low", 32'(sclk), 32'd0);
        chk("midrst_init_done", 32'(init_done), 32'd0);
        chk("midrst_rdata_cleared", 32'(host_rdata), 32'd0);
        model_rdata = 8'h00;
        expq.delete();
        push_init();
        repeat (2) @(posedge clk);
        run_init(1'b0);
        chk("a_all_frames_seen", 32'(expq.size()), 32'd0);

        // Instance B: init then three back-to-back host writes.
        expb.push_back(24'h000800);
        expb.push_back(24'h001400);
        expb.push_back(24'h001600);
        expb.push_back(24'h00FF01);
        for (int k = 0; k < 3; k++) expb.push_back(24'h001855);
        host_req_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (acks_b == 3) begin
                found = 1'b1;
                break;
            end
        end
        host_req_b = 1'b0;
        chk("b_three_acks_seen", 32'(found), 32'd1);
        repeat (60) @(negedge clk);
        chk("b_frames_started", 32'(starts_b), 32'd7);
        chk("b_frames_ended", 32'(ends_b), 32'd7);
        chk("b_ack_total", 32'(acks_b), 32'd3);
        chk("b_all_frames_seen", 32'(expb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
